// File: rtl/qam_demapper_mq.sv
// Hard-decision square M-QAM demapper: optional DC-offset calibration, per-axis
// Gray-coded decision and MSB-first serialisation of the 2*B-bit symbol word.
module qam_demapper_mq #(
  parameter int IN_W      = 8,
  parameter int B         = 2,
  parameter int STEP_LOG2 = 4,
  parameter int CAL_LOG2  = 2
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cal,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic signed [IN_W-1:0] I_in,
  input  logic signed [IN_W-1:0] Q_in,
  output logic                   data_out,
  output logic                   data_valid,
  output logic                   sym_start,
  output logic                   cal_done
);

  localparam int L    = 1 << B;
  localparam int W2   = 2 * B;
  localparam int AW   = IN_W + CAL_LOG2;
  localparam int BC_W = $clog2(W2) + 1;

  localparam logic signed [IN_W:0]   C_MAX  = {2'b00, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W:0]   C_MIN  = {2'b11, {(IN_W-1){1'b0}}};
  localparam logic signed [IN_W+1:0] K_MAX  = (IN_W+2)'(L - 1);
  localparam logic signed [IN_W+1:0] K_HALF = (IN_W+2)'(L / 2);

  typedef enum logic [1:0] {IDLE, CAL, LOAD, SHIFT} state_t;

  state_t                 state, state_nx;
  logic signed [IN_W-1:0] i_r, q_r;
  logic signed [IN_W-1:0] off_i, off_q;
  logic signed [AW-1:0]   acc_i, acc_q;
  logic signed [AW-1:0]   sum_i, sum_q;
  logic [CAL_LOG2-1:0]    cnt;
  logic [W2-1:0]          sr;
  logic [BC_W-1:0]        bitcnt;
  logic                   cal_done_r;
  logic                   accept;
  logic                   cal_last;
  logic                   last_bit;

  // Offset-correct, saturate, slice into one of L levels, then Gray-code.
  function automatic logic [B-1:0] decide(input logic signed [IN_W-1:0] s,
                                          input logic signed [IN_W-1:0] off);
    logic signed [IN_W:0]   c;
    logic signed [IN_W-1:0] cs;
    logic signed [IN_W-1:0] sh;
    logic signed [IN_W+1:0] k;
    logic [B-1:0]           kb;
    c = {s[IN_W-1], s} - {off[IN_W-1], off};
    if (c > C_MAX)      cs = C_MAX[IN_W-1:0];
    else if (c < C_MIN) cs = C_MIN[IN_W-1:0];
    else                cs = c[IN_W-1:0];
    sh = cs >>> (STEP_LOG2 + 1);
    k  = {{2{sh[IN_W-1]}}, sh} + K_HALF;
    if (k[IN_W+1])      kb = '0;
    else if (k > K_MAX) kb = '1;
    else                kb = k[B-1:0];
    return kb ^ (kb >> 1);
  endfunction

  assign sym_ready  = rst & en & ((state == IDLE) | (state == CAL));
  assign accept     = sym_valid & sym_ready;
  assign sum_i      = acc_i + {{CAL_LOG2{I_in[IN_W-1]}}, I_in};
  assign sum_q      = acc_q + {{CAL_LOG2{Q_in[IN_W-1]}}, Q_in};
  assign cal_last   = (state == CAL) & accept & (cnt == '1);
  assign last_bit   = (bitcnt == BC_W'(W2 - 1));

  assign data_out   = sr[W2-1];
  assign data_valid = en & (state == SHIFT);
  assign sym_start  = data_valid & (bitcnt == '0);
  assign cal_done   = cal_done_r;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (en) begin
          if (cal)         state_nx = CAL;
          else if (accept) state_nx = LOAD;
        end
      end
      CAL:     if (cal_last)          state_nx = IDLE;
      LOAD:    if (en)                state_nx = SHIFT;
      SHIFT:   if (en && last_bit)    state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      i_r        <= '0;
      q_r        <= '0;
      off_i      <= '0;
      off_q      <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      cnt        <= '0;
      sr         <= '0;
      bitcnt     <= '0;
      cal_done_r <= 1'b0;
    end else begin
      cal_done_r <= cal_last;
      if (en) begin
        case (state)
          IDLE: begin
            if (!cal && accept) begin
              i_r <= I_in;
              q_r <= Q_in;
            end
          end
          CAL: begin
            if (accept) begin
              if (cnt == '1) begin
                // Upper IN_W bits of the sum are the floor-divided mean.
                off_i <= sum_i[AW-1:CAL_LOG2];
                off_q <= sum_q[AW-1:CAL_LOG2];
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
              end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
                cnt   <= cnt + CAL_LOG2'(1);
              end
            end
          end
          LOAD: begin
            sr     <= {decide(i_r, off_i), decide(q_r, off_q)};
            bitcnt <= '0;
          end
          SHIFT: begin
            sr     <= sr << 1;
            bitcnt <= bitcnt + BC_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qam_demapper_mq.sv
// Directed bench for qam_demapper_mq: 16QAM default build plus a 64QAM build.
module tb_qam_demapper_mq;

  logic              sclk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              cal = 1'b0;
  logic              sym_valid = 1'b0;
  logic signed [7:0] I_in = '0;
  logic signed [7:0] Q_in = '0;
  logic              sym_ready, data_out, data_valid, sym_start, cal_done;

  logic              cal2 = 1'b0;
  logic              sym_valid2 = 1'b0;
  logic signed [7:0] I2 = '0;
  logic signed [7:0] Q2 = '0;
  logic              sym_ready2, data_out2, data_valid2, sym_start2, cal_done2;

  int n_checks = 0;
  int n_pass = 0;
  int cal_pulses = 0;

  qam_demapper_mq #(.IN_W(8), .B(2), .STEP_LOG2(4), .CAL_LOG2(2)) dut (
    .sclk(sclk), .rst(rst), .en(en), .cal(cal),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .I_in(I_in), .Q_in(Q_in),
    .data_out(data_out), .data_valid(data_valid), .sym_start(sym_start),
    .cal_done(cal_done)
  );

  qam_demapper_mq #(.IN_W(8), .B(3), .STEP_LOG2(4), .CAL_LOG2(2)) dut64 (
    .sclk(sclk), .rst(rst), .en(en), .cal(cal2),
    .sym_valid(sym_valid2), .sym_ready(sym_ready2), .I_in(I2), .Q_in(Q2),
    .data_out(data_out2), .data_valid(data_valid2), .sym_start(sym_start2),
    .cal_done(cal_done2)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) if (cal_done) cal_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input logic signed [7:0] i, input logic signed [7:0] q);
    logic ok;
    ok = 1'b0;
    I_in = i; Q_in = q; sym_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge sclk);
      if (sym_ready) begin
        @(posedge sclk);
        ok = 1'b1;
      end
    end
    #1 sym_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic run_sym(input logic signed [7:0] i, input logic signed [7:0] q,
                         output logic [7:0] word, output logic [7:0] starts, output int nv);
    word = '0; starts = '0; nv = 0;
    send(i, q);
    for (int k = 0; k < 8; k++) begin
      @(negedge sclk);
      if (data_valid) begin
        word   = {word[6:0], data_out};
        starts = {starts[6:0], sym_start};
        nv++;
      end
    end
  endtask

  task automatic do_cal(input logic signed [7:0] i, input logic signed [7:0] q);
    @(negedge sclk); cal = 1'b1;
    @(posedge sclk); #1 cal = 1'b0;
    repeat (4) send(i, q);
    repeat (2) @(negedge sclk);
  endtask

  initial begin
    logic [7:0] w, s;
    int nv, n_rdy, n_dv, n_st, frz_bad, frz_ones;

    #2 check("rst_outs", {data_out, data_valid, sym_start, cal_done, sym_ready}, 0);
    @(posedge sclk); #1 rst = 1'b1;
    @(negedge sclk); check("ready_en0", sym_ready, 0);
    en = 1'b1;
    #1 check("ready_idle", sym_ready, 1);

    // Decision thresholds and Gray coding on I, Q fixed at 48 (bits 10)
    run_sym(-48, 48, w, s, nv); check("gray_i_m48", w, 8'h02);
    run_sym(-16, 48, w, s, nv); check("gray_i_m16", w, 8'h06);
    run_sym( 16, 48, w, s, nv); check("gray_i_p16", w, 8'h0E);
    run_sym( 48, 48, w, s, nv); check("gray_i_p48", w, 8'h0A);
    run_sym(48, -16, w, s, nv);
    check("ser_word", w, 8'h09);
    check("ser_nvalid", nv, 4);
    check("ser_start", s, 8'h08);

    // Calibration removes the 4/-2 offset
    do_cal(4, -2);
    check("cal_pulse1", cal_pulses, 1);
    run_sym(52, -18, w, s, nv); check("cal_word", w, 8'h09);

    // Saturation before decision, then clamp to outer level
    do_cal(-100, 0);
    check("cal_pulse2", cal_pulses, 2);
    run_sym(127, 0, w, s, nv);  check("sat_pos", w, 8'h0B);
    run_sym(-128, 0, w, s, nv); check("off_m128", w, 8'h07);

    // Reset mid-SHIFT: outputs drop at once, offsets cleared
    send(16, 48);
    @(negedge sclk); @(negedge sclk);
    check("pre_rst_dv", {data_valid, data_out}, 2'b11);
    #1 rst = 1'b0;
    #1 check("rst_shift_outs", {data_out, data_valid, sym_start, cal_done, sym_ready}, 0);
    @(posedge sclk); #1 rst = 1'b1;
    run_sym(-128, 0, w, s, nv); check("raw_m128", w, 8'h03);

    // Continuous sym_valid: one accept every 6 cycles
    I_in = 16; Q_in = 48;
    @(posedge sclk); #1 sym_valid = 1'b1;
    n_rdy = 0; n_dv = 0; n_st = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge sclk);
      if (sym_ready)  n_rdy++;
      if (data_valid) n_dv++;
      if (sym_start)  n_st++;
    end
    @(posedge sclk); #1 sym_valid = 1'b0;
    check("tp_ready", n_rdy, 3);
    check("tp_valid", n_dv, 12);
    check("tp_start", n_st, 3);

    // en dropped for 3 cycles mid-SHIFT on word 1110 (frozen on a 1 bit)
    send(16, 48);
    w = '0; nv = 0; frz_bad = 0; frz_ones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sclk);
      if (!en) begin
        if (data_valid || sym_start || sym_ready) frz_bad++;
        if (data_out) frz_ones++;
      end
      if (data_valid) begin
        w = {w[6:0], data_out};
        nv++;
      end
      @(posedge sclk);
      #1 en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
    end
    check("frz_word", w, 8'h0E);
    check("frz_nvalid", nv, 4);
    check("frz_outs_low", frz_bad, 0);
    check("frz_dout_hold", frz_ones, 3);

    // Reset mid-CAL: partial accumulation discarded, no pulse
    @(negedge sclk); cal = 1'b1;
    @(posedge sclk); #1 cal = 1'b0;
    send(40, 40);
    send(40, 40);
    #2 rst = 1'b0;
    #1 check("rst_cal_outs", {data_out, data_valid, sym_start, cal_done, sym_ready}, 0);
    @(posedge sclk); #1 rst = 1'b1;
    run_sym(48, -16, w, s, nv); check("post_rst_word", w, 8'h09);
    check("no_cal_pulse", cal_pulses, 2);
    do_cal(8, 8);
    check("cal_pulse3", cal_pulses, 3);
    run_sym(56, -8, w, s, nv); check("recal_word", w, 8'h09);

    // 64QAM build: k 7/0 -> 100 000
    I2 = 112; Q2 = -112; sym_valid2 = 1'b1;
    n_rdy = 0;
    for (int t = 0; t < 20 && n_rdy == 0; t++) begin
      @(negedge sclk);
      if (sym_ready2) begin
        @(posedge sclk);
        n_rdy = 1;
      end
    end
    #1 sym_valid2 = 1'b0;
    check("q64_accept", n_rdy, 1);
    w = '0; nv = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sclk);
      if (data_valid2) begin
        w = {w[6:0], data_out2};
        nv++;
      end
    end
    check("q64_word", w, 8'h20);
    check("q64_nvalid", nv, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
